// File: rtl/operand_stack.sv
// Operand stack with registered TOS/NOS and a spill RAM holding the deeper entries.
// Optional sticky overflow/underflow flags are enabled with the OPSTACK_ERR_EN macro.
module operand_stack #(
    parameter int VALUE_WIDTH = 16,
    parameter int DEPTH       = 16,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [VALUE_WIDTH-1:0] push_data,
    input  logic                   err_clr,
    output logic [VALUE_WIDTH-1:0] tos,
    output logic [VALUE_WIDTH-1:0] nos,
    output logic [CNT_W-1:0]       depth,
    output logic                   empty,
    output logic                   full,
    output logic                   zero_flag,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int RAM_DEPTH = DEPTH - 2;
    localparam int AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [VALUE_WIDTH-1:0] tos_reg, tos_next;
    logic [VALUE_WIDTH-1:0] nos_reg, nos_next;
    logic [CNT_W-1:0]       depth_reg, depth_next;
    logic                   zero_reg, zero_next;
    logic                   ovf_evt, udf_evt;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr, rd_addr;

    // spill_q always holds ram[depth_reg-3], prefetched with the next-state depth
    logic [VALUE_WIDTH-1:0] spill_ram [RAM_DEPTH];
    logic [VALUE_WIDTH-1:0] spill_q;

    assign empty = (depth_reg == '0);
    assign full  = (depth_reg == CNT_W'(DEPTH));

    always_comb begin
        tos_next   = tos_reg;
        nos_next   = nos_reg;
        depth_next = depth_reg;
        wr_en      = 1'b0;
        ovf_evt    = 1'b0;
        udf_evt    = 1'b0;
        if (push && !pop) begin
            if (full) begin
                ovf_evt = 1'b1;
            end else begin
                nos_next   = tos_reg;
                tos_next   = push_data;
                depth_next = depth_reg + CNT_W'(1);
                wr_en      = (depth_reg >= CNT_W'(2)) && !rst;
            end
        end else if (pop && !push) begin
            if (empty) begin
                udf_evt = 1'b1;
            end else begin
                tos_next   = nos_reg;
                depth_next = depth_reg - CNT_W'(1);
                nos_next   = (depth_reg >= CNT_W'(3)) ? spill_q : '0;
            end
        end else if (push && pop) begin
            tos_next = push_data;
            if (empty) begin
                udf_evt    = 1'b1;
                depth_next = CNT_W'(1);
            end
        end
        zero_next = (depth_next != '0) && (tos_next == '0);
        wr_addr   = AW'(depth_reg - CNT_W'(2));
        rd_addr   = (depth_next >= CNT_W'(3)) ? AW'(depth_next - CNT_W'(3)) : '0;
    end

    // After a push the prefetch address equals the write address, so bypass the write data
    always_ff @(posedge clk) begin
        if (wr_en) begin
            spill_ram[wr_addr] <= nos_reg;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            spill_q <= nos_reg;
        end else begin
            spill_q <= spill_ram[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_reg   <= '0;
            nos_reg   <= '0;
            depth_reg <= '0;
            zero_reg  <= 1'b0;
        end else begin
            tos_reg   <= tos_next;
            nos_reg   <= nos_next;
            depth_reg <= depth_next;
            zero_reg  <= zero_next;
        end
    end

`ifdef OPSTACK_ERR_EN
    logic ovf_reg, udf_reg;

    // A new event takes priority over a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            if (ovf_evt)      ovf_reg <= 1'b1;
            else if (err_clr) ovf_reg <= 1'b0;
            if (udf_evt)      udf_reg <= 1'b1;
            else if (err_clr) udf_reg <= 1'b0;
        end
    end

    assign overflow  = ovf_reg;
    assign underflow = udf_reg;
`else
    logic unused_err;
    assign unused_err = err_clr ^ ovf_evt ^ udf_evt;
    assign overflow   = 1'b0;
    assign underflow  = 1'b0;
`endif

    assign tos       = tos_reg;
    assign nos       = nos_reg;
    assign depth     = depth_reg;
    assign zero_flag = zero_reg;

endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack (VALUE_WIDTH=16, DEPTH=4); expected states come from a queue-based stack model.
module tb_operand_stack;
    localparam int VW    = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [VW-1:0] push_data = '0;
    logic          err_clr = 1'b0;
    logic [VW-1:0] tos, nos;
    logic [CNT_W-1:0] depth;
    logic          empty, full, zero_flag, overflow, underflow;

    operand_stack #(.VALUE_WIDTH(VW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
        .err_clr(err_clr), .tos(tos), .nos(nos), .depth(depth), .empty(empty),
        .full(full), .zero_flag(zero_flag), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] tos;
        logic [VW-1:0] nos;
        int            depth;
        logic          empty;
        logic          full;
        logic          zero;
        logic          ovf;
        logic          udf;
    } exp_t;

    exp_t          exp_q[$];
    logic [VW-1:0] m_stk[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    int            checks = 0;
    int            errors = 0;
    int            txn = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference model update, then snapshot of the expected post-edge state
    task automatic model(input logic r, input logic pu, input logic po, input logic [VW-1:0] d, input logic clr);
        exp_t e;
        logic ov, un;
        ov = 1'b0;
        un = 1'b0;
        if (r) begin
            m_stk.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (pu && !po) begin
                if (m_stk.size() == DEPTH) ov = 1'b1;
                else m_stk.push_back(d);
            end else if (po && !pu) begin
                if (m_stk.size() == 0) un = 1'b1;
                else void'(m_stk.pop_back());
            end else if (pu && po) begin
                if (m_stk.size() == 0) begin
                    un = 1'b1;
                    m_stk.push_back(d);
                end else begin
                    m_stk[m_stk.size()-1] = d;
                end
            end
`ifdef OPSTACK_ERR_EN
            if (ov) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
            if (un) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
`endif
        end
        e.depth = m_stk.size();
        e.tos   = (e.depth >= 1) ? m_stk[e.depth-1] : '0;
        e.nos   = (e.depth >= 2) ? m_stk[e.depth-2] : '0;
        e.empty = (e.depth == 0);
        e.full  = (e.depth == DEPTH);
        e.zero  = (e.depth >= 1) && (e.tos == '0);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic pu, input logic po, input logic [VW-1:0] d, input logic clr);
        exp_t e;
        int err0;
        @(negedge clk);
        rst = r; push = pu; pop = po; push_data = d; err_clr = clr;
        model(r, pu, po, d, clr);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        err0 = errors;
        check("tos",       32'(tos),       32'(e.tos));
        check("nos",       32'(nos),       32'(e.nos));
        check("depth",     32'(depth),     32'(e.depth));
        check("empty",     32'(empty),     32'(e.empty));
        check("full",      32'(full),      32'(e.full));
        check("zero_flag", 32'(zero_flag), 32'(e.zero));
        check("overflow",  32'(overflow),  32'(e.ovf));
        check("underflow", 32'(underflow), 32'(e.udf));
        $display("txn %0d rst=%0b push=%0b pop=%0b data=%0h clr=%0b -> tos=%0h nos=%0h depth=%0d z=%0b ovf=%0b udf=%0b %s",
                 txn, r, pu, po, d, clr, tos, nos, depth, zero_flag, overflow, underflow,
                 (errors == err0) ? "ok" : "bad");
        txn++;
    endtask

    task automatic idle();
        rst = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        // 1: reset
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_tos", 32'(tos), 0);
        check("rst_empty", 32'(empty), 1);
        // 2: push 5,0,7 then pop twice
        step(0, 1, 0, 5, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 7, 0);
        check("s2_tos", 32'(tos), 7);
        check("s2_depth", 32'(depth), 3);
        step(0, 0, 1, 0, 0);
        check("s2_zero", 32'(zero_flag), 1);
        check("s2_nos", 32'(nos), 5);
        step(0, 0, 1, 0, 0);
        check("s2_tos_b", 32'(tos), 5);
        // 3: fill, overflow, drain through spill RAM
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, 0, VW'(i), 0);
        step(0, 1, 0, 9, 0);
        check("s3_full", 32'(full), 1);
        check("s3_tos", 32'(tos), 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            check("s3_drain", 32'(tos), 32'(3 - i));
        end
        check("s3_empty", 32'(empty), 1);
        // 4: underflow and clear
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        // 5: replace, and push&pop on empty
        step(0, 1, 0, 6, 0);
        step(0, 1, 0, 8, 0);
        step(0, 1, 1, 0, 0);
        check("s5_nos", 32'(nos), 6);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 3, 0);
        check("s5_tos", 32'(tos), 3);
        // 6: push coincident with reset
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 2, 0);
        step(1, 1, 0, 4, 0);
        check("s6_depth", 32'(depth), 0);
        // random traffic with biased push/pop to reach both ends
        for (int i = 0; i < 300; i++) begin
            logic pu, po, cl, rr;
            logic [VW-1:0] d;
            pu = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 65 : 35));
            po = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 65));
            cl = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 99) == 0);
            d  = ($urandom_range(0, 3) == 0) ? '0 : VW'($urandom);
            step(rr, pu, po, d, cl);
        end
        @(negedge clk);
        idle();
        if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
